mux_scan_n: RTL and testbench
=============================

# mux_scan_n

Parametrised, registered N-channel multiplexer for the calculator datapath and display front end. It selects one of CHANNELS operand/digit words of WIDTH bits in one of two modes: manual, where the select comes from the controller, or scan, where an internal dwell counter steps round-robin through all channels to drive time-multiplexed digit strobes. It sits between the result/digit registers and the display driver, and replaces fixed-size combinational selectors wherever a registered or scanned select is needed.

## Interface
Parameters:
- WIDTH, 6: bits per channel word.
- CHANNELS, 8: number of input channels, 2..16.
- SEL_W, 3: select width; must equal ceil(log2(CHANNELS)).
- DWELL, 1024: clock cycles each channel is held in scan mode, 2..65536.
- BLANK, 2: strobe blanking cycles per dwell, 1..DWELL-1; used only with the blanking macro.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  CHANNELS*WIDTH  flattened channel words; channel k occupies bits [k*WIDTH +: WIDTH].
- mode  in  1  0 = manual, 1 = scan.
- sel_in  in  SEL_W  manual-mode channel select.
- enable  in  1  1 = advance/update; 0 = freeze all state.
- data_out  out  WIDTH  registered selected word.
- sel_out  out  SEL_W  registered current channel index.
- sel_onehot  out  CHANNELS  registered one-hot digit strobe, active high.
- wrap  out  1  one-cycle pulse when the scan wraps from CHANNELS-1 to 0.

## Operation
- State:
  - sel register (SEL_W bits).
  - dwell counter (ceil(log2(DWELL)) bits).
  - prev_mode flag.
  - Output registers.
- Reset (rst_n low, asynchronous): sel=0, counter=0, prev_mode=0, data_out=0, sel_out=0, sel_onehot=0, wrap=0.
- enable=0: no register changes, including data_out. wrap is forced to 0.
- Manual mode (mode=0, enable=1):
  - Each cycle sel <= sel_in and counter <= 0.
  - sel_in >= CHANNELS saturates to CHANNELS-1.
- Scan mode (mode=1, enable=1):
  - If counter==DWELL-1, the counter goes to 0 and sel advances by 1; CHANNELS-1 wraps to 0 and asserts wrap for that cycle.
  - Otherwise the counter increments and sel holds.
- Mode change:
  - manual->scan: the counter starts at 0 on the current sel, and the first dwell is a full DWELL cycles.
  - scan->manual: sel_in is loaded on the same edge and the counter clears.
- Output update each enabled cycle:
  - data_out <= data_in slice of the next sel.
  - sel_out <= next sel.
  - sel_onehot <= 1<<next sel.
- data_out re-samples data_in every enabled cycle, so a live input change appears after 1 cycle even within a dwell.

## Timing
- Latency is 1 cycle from sel_in/data_in to data_out, sel_out and sel_onehot.
- Scan period is DWELL*CHANNELS cycles. wrap asserts once per period, coincident with sel_out returning to 0.
- Reset deasserted mid-scan restarts at channel 0 with counter 0. The first output update occurs on the first enabled edge after release.
- If mode and enable toggle on the same edge, enable has priority: with enable=0, nothing changes and prev_mode is not updated.

## Configuration
- MUX_SCAN_BLANK_EN defined:
  - In scan mode, sel_onehot is forced to 0 while counter < BLANK, i.e. the first BLANK cycles of every dwell, to suppress display ghosting.
  - data_out and sel_out are unaffected.
  - Manual mode is never blanked.
- MUX_SCAN_BLANK_EN undefined: sel_onehot always equals 1<<sel_out after reset, and BLANK is ignored.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Release with mode=0, sel_in=5, enable=1, channel 5=6'h2A (WIDTH=6, CHANNELS=8) -> next edge gives data_out=6'h2A, sel_out=5, sel_onehot=8'h20.
- Manual saturation: CHANNELS=6, sel_in=7 -> sel_out=5, data_out=channel 5 after 1 cycle.
- Scan: DWELL=4, CHANNELS=8 -> sel_out steps 0,1,...,7,0 every 4 cycles. wrap is high for exactly 1 cycle every 32 cycles, when sel_out becomes 0. Change a channel word mid-dwell -> data_out follows 1 cycle later.
- Freeze: in scan, drop enable for 10 cycles at counter=2 -> outputs constant and wrap=0. Re-enable -> channel advances after exactly 2 more cycles.
- Mode switch: scan at sel=3, switch to manual with sel_in=6 -> sel_out=6 next edge. Return to scan -> sel holds 6 for 4 cycles (DWELL=4), then 7.
- Blanking (MUX_SCAN_BLANK_EN, DWELL=4, BLANK=2) -> sel_onehot=0 for 2 cycles, then one-hot for 2 cycles, each dwell; data_out is unaffected. Build without the macro -> never zero after reset.

Source files
------------

// File: rtl/mux_scan_n.sv
// Registered N-channel word mux with manual select or round-robin dwell scan; 1-cycle latency.
// enable=0 freezes every register and clears wrap. Optional strobe blanking: MUX_SCAN_BLANK_EN.
module mux_scan_n #(
  parameter int WIDTH    = 6,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 1024,
  parameter int BLANK    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      enable,
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          sel_out,
  output logic [CHANNELS-1:0]       sel_onehot,
  output logic                      wrap
);

  localparam int CNT_W = $clog2(DWELL);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_CNT = CNT_W'(BLANK);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(CHANNELS - 1);
`ifdef MUX_SCAN_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic [SEL_W-1:0]    sel_q, sel_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_cur, cnt_nxt;
  logic                prev_mode_q;
  logic                wrap_nxt;
  logic [WIDTH-1:0]    data_nxt;
  logic [CHANNELS-1:0] onehot_nxt;

  always_comb begin
    sel_nxt    = sel_q;
    cnt_nxt    = cnt_q;
    wrap_nxt   = 1'b0;
    // entering scan always begins a fresh dwell on the held channel
    cnt_cur    = prev_mode_q ? cnt_q : '0;
    if (!mode) begin
      sel_nxt = (sel_in > SEL_LAST) ? SEL_LAST : sel_in;
      cnt_nxt = '0;
    end else if (cnt_cur == CNT_LAST) begin
      cnt_nxt = '0;
      if (sel_q == SEL_LAST) begin
        sel_nxt  = '0;
        wrap_nxt = 1'b1;
      end else begin
        sel_nxt = sel_q + 1'b1;
      end
    end else begin
      cnt_nxt = cnt_cur + 1'b1;
    end

    data_nxt   = data_in[int'(sel_nxt)*WIDTH +: WIDTH];
    onehot_nxt = CHANNELS'(1) << sel_nxt;
    // strobe dark for the first BLANK cycles of each dwell to hide ghosting
    if (BLANK_ON && mode && (cnt_nxt < BLANK_CNT))
      onehot_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= '0;
      cnt_q       <= '0;
      prev_mode_q <= 1'b0;
      data_out    <= '0;
      sel_out     <= '0;
      sel_onehot  <= '0;
      wrap        <= 1'b0;
    end else if (enable) begin
      sel_q       <= sel_nxt;
      cnt_q       <= cnt_nxt;
      prev_mode_q <= mode;
      data_out    <= data_nxt;
      sel_out     <= sel_nxt;
      sel_onehot  <= onehot_nxt;
      wrap        <= wrap_nxt;
    end else begin
      wrap        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: a reference model pushes expected outputs per edge, popped after the edge.
module tb_mux_scan_n;
  localparam int W  = 6;
  localparam int C  = 8;
  localparam int SW = 3;
  localparam int DW = 4;
  localparam int BL = 2;
  localparam int C2 = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [C*W-1:0]  data_in;
  logic            mode, enable;
  logic [SW-1:0]   sel_in;
  logic [W-1:0]    data_out;
  logic [SW-1:0]   sel_out;
  logic [C-1:0]    sel_onehot;
  logic            wrap;

  logic [C2*W-1:0] data_in6;
  logic            mode6, enable6;
  logic [SW-1:0]   sel_in6;
  logic [W-1:0]    data_out6;
  logic [SW-1:0]   sel_out6;
  logic [C2-1:0]   sel_onehot6;
  logic            wrap6;

  mux_scan_n #(.WIDTH(W), .CHANNELS(C), .SEL_W(SW), .DWELL(DW), .BLANK(BL)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .mode(mode), .sel_in(sel_in),
    .enable(enable), .data_out(data_out), .sel_out(sel_out),
    .sel_onehot(sel_onehot), .wrap(wrap));

  mux_scan_n #(.WIDTH(W), .CHANNELS(C2), .SEL_W(SW), .DWELL(DW), .BLANK(BL)) dut6 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in6), .mode(mode6), .sel_in(sel_in6),
    .enable(enable6), .data_out(data_out6), .sel_out(sel_out6),
    .sel_onehot(sel_onehot6), .wrap(wrap6));

  typedef struct packed {
    logic [W-1:0]  d;
    logic [SW-1:0] s;
    logic [C-1:0]  oh;
    logic          w;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   m_sel, m_cnt;
  int   total = 0;
  int   bad   = 0;
  int   wraps, zeros;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sel = 0;
    m_cnt = 0;
    last  = '0;
  endtask

  // Predict the next edge from the current inputs, clock it, then compare.
  task automatic step(input string tag);
    exp_t e;
    int   ns, nc;
    logic w;
    if (!enable) begin
      e   = last;
      e.w = 1'b0;
    end else begin
      w = 1'b0;
      if (!mode) begin
        ns = (int'(sel_in) >= C) ? C - 1 : int'(sel_in);
        nc = 0;
      end else if (m_cnt == DW - 1) begin
        nc = 0;
        ns = (m_sel + 1) % C;
        w  = (m_sel == C - 1);
      end else begin
        nc = m_cnt + 1;
        ns = m_sel;
      end
      m_sel = ns;
      m_cnt = nc;
      e.d  = data_in[ns*W +: W];
      e.s  = SW'(ns);
      e.oh = C'(1) << ns;
      e.w  = w;
`ifdef MUX_SCAN_BLANK_EN
      if (mode && nc < BL) e.oh = '0;
`endif
    end
    last = e;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, ".data_out"},   32'(data_out),   32'(e.d));
    chk({tag, ".sel_out"},    32'(sel_out),    32'(e.s));
    chk({tag, ".sel_onehot"}, 32'(sel_onehot), 32'(e.oh));
    chk({tag, ".wrap"},       32'(wrap),       32'(e.w));
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b1;
    mode     = 1'b0;
    sel_in   = '0;
    data_in  = '0;
    mode6    = 1'b0;
    enable6  = 1'b1;
    sel_in6  = 3'd7;
    data_in6 = '0;
    model_reset();

    // reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      data_in = {$urandom, $urandom};
      mode    = 1'($urandom);
      enable  = 1'($urandom);
      sel_in  = 3'($urandom);
      @(posedge clk);
      #1;
      chk("rst.data_out",   32'(data_out),   32'h0);
      chk("rst.sel_out",    32'(sel_out),    32'h0);
      chk("rst.sel_onehot", 32'(sel_onehot), 32'h0);
      chk("rst.wrap",       32'(wrap),       32'h0);
    end

    // release into manual select of channel 5, and saturating select on the 6-channel instance
    mode    = 1'b0;
    enable  = 1'b1;
    sel_in  = 3'd5;
    data_in = {$urandom, $urandom};
    data_in[5*W +: W] = 6'h2A;
    data_in6 = 36'($urandom) ^ (36'($urandom) << 16);
    data_in6[5*W +: W] = 6'h33;
    rst_n   = 1'b1;
    step("first");
    chk("first.data_2a", 32'(data_out),    32'h2A);
    chk("first.sel5",    32'(sel_out),     32'h5);
    chk("first.oh20",    32'(sel_onehot),  32'h20);
    chk("sat.sel_out",   32'(sel_out6),    32'h5);
    chk("sat.data_out",  32'(data_out6),   32'h33);
    chk("sat.onehot",    32'(sel_onehot6), 32'h20);

    // manual select over every channel with fresh data
    for (int i = 0; i < C; i++) begin
      sel_in  = 3'(i);
      data_in = {$urandom, $urandom};
      step("manual");
    end

    // scan from channel 0: two full periods
    sel_in = 3'd0;
    step("to0");
    mode  = 1'b1;
    wraps = 0;
    for (int i = 1; i <= 2 * C * DW; i++) begin
      if (i == 6) data_in[1*W +: W] = 6'h15;
      step("scan");
      if (i == 6) chk("live.data", 32'(data_out), 32'h15);
      if (wrap) begin
        wraps++;
        chk("wrap.sel0", 32'(sel_out), 32'h0);
        chk("wrap.when", 32'(i % (C * DW)), 32'h0);
      end
    end
    chk("wrap.count", 32'(wraps), 32'd2);

    // freeze at counter 2; mode also wiggles while disabled
    step("pre_frz");
    step("pre_frz");
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      data_in = {$urandom, $urandom};
      mode    = 1'(i);
      step("frz");
    end
    mode   = 1'b1;
    enable = 1'b1;
    step("unfrz");
    chk("unfrz.hold", 32'(sel_out), 32'h0);
    step("unfrz");
    chk("unfrz.adv", 32'(sel_out), 32'h1);

    // scan on to channel 3, go manual to 6, back to scan
    for (int i = 0; i < 4 * DW && m_sel != 3; i++) step("to3");
    chk("reach3", 32'(sel_out), 32'h3);
    mode   = 1'b0;
    sel_in = 3'd6;
    step("sw_man");
    chk("sw_man.sel6", 32'(sel_out), 32'h6);
    mode = 1'b1;
    for (int i = 0; i < DW - 1; i++) begin
      step("sw_scan");
      chk("sw_scan.hold6", 32'(sel_out), 32'h6);
    end
    step("sw_scan");
    chk("sw_scan.sel7", 32'(sel_out), 32'h7);

    // strobe blanking over four dwells
    zeros = 0;
    for (int i = 0; i < 4 * DW; i++) begin
      step("blank");
      if (sel_onehot == '0) zeros++;
    end
`ifdef MUX_SCAN_BLANK_EN
    chk("blank.zeros", 32'(zeros), 32'd8);
`else
    chk("blank.zeros", 32'(zeros), 32'd0);
`endif

    // asynchronous reset mid-scan, then restart from channel 0
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.sel_out", 32'(sel_out),    32'h0);
    chk("arst.onehot",  32'(sel_onehot), 32'h0);
    chk("arst.data",    32'(data_out),   32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DW + 1; i++) step("restart");
    chk("restart.sel1", 32'(sel_out), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timeout");
  end

endmodule
